// File: rtl/ifu_pkg.sv
// Shared IFU constants and the fetch-line type used by the instruction memory and its benches.
package ifu_pkg;

  localparam int LINE_W     = 128;
  localparam int OFFSET_W   = 4;
  localparam int IMEM_DEPTH = 1024;

  typedef logic [LINE_W-1:0] t_line;

endpackage

// File: rtl/i_mem_array.sv
// Plain line storage: one synchronous write port, asynchronous read of idx.
module i_mem_array
  import ifu_pkg::*;
#(
  parameter int DATA_WIDTH = LINE_W,
  parameter int MEM_DEPTH  = IMEM_DEPTH,
  parameter     INIT_FILE  = "",
  localparam int IDX_W     = $clog2(MEM_DEPTH)
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [IDX_W-1:0]      idx,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/i_mem.sv
// IFU instruction memory: line-addressed storage with range check, write-through and a registered q.
module i_mem
  import ifu_pkg::*;
#(
  parameter int DATA_WIDTH = LINE_W,
  parameter int ADRS_WIDTH = 32,
  parameter int MEM_DEPTH  = IMEM_DEPTH,
  parameter     INIT_FILE  = ""
) (
  input  logic                         clock,
  input  logic                         rst_n,
  input  logic [ADRS_WIDTH-OFFSET_W-1:0] address,
  input  logic                         wren,
  input  logic [DATA_WIDTH-1:0]        data,
  output logic [DATA_WIDTH-1:0]        q
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  logic [IDX_W-1:0]      idx;
  logic                  in_range;
  logic                  we;
  logic [DATA_WIDTH-1:0] rdata;

  // Lines above MEM_DEPTH are rejected rather than aliased onto low lines.
  assign idx      = address[IDX_W-1:0];
  assign in_range = (address[ADRS_WIDTH-OFFSET_W-1:IDX_W] == '0);
  assign we       = rst_n & wren & in_range;

  i_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .INIT_FILE  (INIT_FILE)
  ) u_array (
    .clock (clock),
    .we    (we),
    .idx   (idx),
    .wdata (data),
    .rdata (rdata)
  );

  // Output register stage: write-through on a same-edge write, zero when out of range.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (!in_range) begin
      q <= '0;
    end else if (wren) begin
      q <= data;
    end else begin
      q <= rdata;
    end
  end

endmodule

// File: tb/tb_i_mem.sv
// Directed bench for i_mem with a line-memory reference model and an expected-q scoreboard.
module tb_i_mem;
  import ifu_pkg::*;

  localparam int AW    = 32;
  localparam int LAW   = AW - OFFSET_W;
  localparam int DEPTH = IMEM_DEPTH;
  localparam int IW    = $clog2(DEPTH);

  logic           clock;
  logic           rst_n;
  logic [LAW-1:0] address;
  logic           wren;
  t_line          data;
  t_line          q;

  int errors = 0;
  int checks = 0;

  t_line model [int];
  t_line exp_q [$];
  string tag_q [$];

  i_mem #(
    .DATA_WIDTH (LINE_W),
    .ADRS_WIDTH (AW),
    .MEM_DEPTH  (DEPTH),
    .INIT_FILE  ("")
  ) dut (
    .clock   (clock),
    .rst_n   (rst_n),
    .address (address),
    .wren    (wren),
    .data    (data),
    .q       (q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input t_line obs, input t_line expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: q=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock of stimulus: the model predicts q, the prediction is queued, then popped after the edge.
  task automatic cyc(input string tag, input logic [LAW-1:0] a, input logic w, input t_line d);
    t_line e;
    int    i;
    @(negedge clock);
    address = a;
    wren    = w;
    data    = d;
    if (a[LAW-1:IW] == '0) begin
      i = int'(a[IW-1:0]);
      if (w) begin
        e        = d;
        model[i] = d;
      end else begin
        e = model[i];
      end
    end else begin
      e = '0;
    end
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clock);
    #1;
    check(tag_q.pop_front(), q, exp_q.pop_front());
  endtask

  initial begin
    rst_n   = 1'b1;
    address = '0;
    wren    = 1'b0;
    data    = '0;

    // Power-on reset
    #3 rst_n = 1'b0;
    #1 check("reset_initial", q, '0);
    @(negedge clock);
    rst_n = 1'b1;

    // Make q nonzero, then reset asynchronously mid-cycle while attempting a write
    cyc("wr_line5", LAW'(5), 1'b1, 128'h5555_0000_1234_5678_9ABC_DEF0_0F0F_F0F0);
    cyc("rd_line5", LAW'(5), 1'b0, '0);
    #2 rst_n = 1'b0;
    #1 check("reset_async", q, '0);
    @(negedge clock);
    address = LAW'(5);
    wren    = 1'b1;
    data    = 128'hBAD0_BAD0;
    @(posedge clock);
    #1 check("reset_hold1", q, '0);
    @(posedge clock);
    #1 check("reset_hold2", q, '0);
    @(negedge clock);
    wren  = 1'b0;
    rst_n = 1'b1;
    #1 check("reset_release", q, '0);
    cyc("rd_line5_after_reset", LAW'(5), 1'b0, '0);

    // Write then read lines 1 and 2
    cyc("wr_line1", LAW'(32'h10 >> 4), 1'b1, 128'h1);
    cyc("wr_line2", LAW'(32'h20 >> 4), 1'b1, 128'h2);
    cyc("rd_line1", LAW'(1), 1'b0, '0);
    cyc("rd_line2", LAW'(2), 1'b0, '0);
    check("rd_line2_const", q, 128'h2);

    // Read-during-write is write-through
    cyc("rdw_line3", LAW'(3), 1'b1, 128'hDEAD);
    check("rdw_line3_const", q, 128'hDEAD);
    cyc("rd_line3", LAW'(3), 1'b0, '0);

    // Out-of-range write must not alias onto line 0
    cyc("wr_line0", LAW'(0), 1'b1, 128'hA5A5_5A5A);
    cyc("oor_write", LAW'(DEPTH), 1'b1, 128'hBEEF);
    cyc("oor_read_hi", {1'b1, {(LAW-1){1'b0}}}, 1'b0, '0);
    cyc("rd_line0_no_alias", LAW'(0), 1'b0, '0);
    check("rd_line0_const", q, 128'hA5A5_5A5A);

    // Top boundary lines
    cyc("wr_line_m2", LAW'(DEPTH - 2), 1'b1, 128'h0123_4567_89AB_CDEF);
    cyc("wr_line_m1", LAW'(DEPTH - 1), 1'b1, '1);
    cyc("rd_line_m1", LAW'(DEPTH - 1), 1'b0, '0);
    check("rd_line_m1_const", q, {LINE_W{1'b1}});
    cyc("rd_line_m2", LAW'(DEPTH - 2), 1'b0, '0);

    // Back-to-back writes then reads
    for (int i = 0; i < 8; i++) begin
      cyc($sformatf("b2b_wr%0d", i), LAW'(i), 1'b1, {32'(i), 32'hC0DE_0000 + 32'(i), 32'(i * 7), 32'hFACE});
    end
    for (int i = 0; i < 8; i++) begin
      cyc($sformatf("b2b_rd%0d", i), LAW'(i), 1'b0, '0);
    end
    check("b2b_rd7_const", q, {32'd7, 32'hC0DE_0007, 32'd49, 32'hFACE});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
